// File: rtl/vote_capture.sv
// vote_capture: front end of the voting datapath.
// Synchronises and debounces four candidate buttons, arbitrates so that one
// clean press yields exactly one vote, and keeps four saturating 8-bit tallies.
module vote_capture #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LOCKOUT_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode,
  input  logic       button1,
  input  logic       button2,
  input  logic       button3,
  input  logic       button4,
  output logic [7:0] cand1_vote,
  output logic [7:0] cand2_vote,
  output logic [7:0] cand3_vote,
  output logic [7:0] cand4_vote,
  output logic       cand1_button_press,
  output logic       cand2_button_press,
  output logic       cand3_button_press,
  output logic       cand4_button_press,
  output logic       valid_vote_casted,
  output logic       invalid_press
);

  // Debounce counter only needs to reach DEBOUNCE_CYCLES-1; the level flips
  // on the cycle that would make it DEBOUNCE_CYCLES.
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DEB_ONE  = DW'(1);

  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [LW-1:0] LOCK_INIT = LW'(LOCKOUT_CYCLES);
  localparam logic [LW-1:0] LOCK_ONE  = LW'(1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    LOCKOUT      = 2'd1,
    WAIT_RELEASE = 2'd2
  } state_t;

  logic [3:0]    raw;
  logic [3:0]    sync1;
  logic [3:0]    sync2;
  logic [3:0]    level;
  logic [3:0]    level_prev;
  logic [DW-1:0] deb_cnt [4];

  state_t        state;
  state_t        state_next;
  logic [LW-1:0] lock_cnt;
  logic [LW-1:0] lock_next;
  logic [7:0]    tally [4];

  logic [3:0]    press;
  logic          single_press;
  logic          others_clear;
  logic          accept;
  logic          reject;

  assign raw = {button4, button3, button2, button1};

  // Two-flop synchroniser followed by a per-button persistence debouncer.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1      <= 4'b0000;
      sync2      <= 4'b0000;
      level      <= 4'b0000;
      level_prev <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      sync1      <= raw;
      sync2      <= sync1;
      level_prev <= level;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] != level[i]) begin
          if (deb_cnt[i] == DEB_LAST) begin
            level[i]   <= sync2[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + DEB_ONE;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  // A press is a debounced rising edge; a clean press is the only active button.
  assign press        = level & ~level_prev;
  assign single_press = (press != 4'b0000) && ((press & (press - 4'd1)) == 4'b0000);
  assign others_clear = ((level & ~press) == 4'b0000);

  // Arbitration FSM: next state, lockout count and accept/reject decisions.
  always_comb begin
    state_next = state;
    lock_next  = lock_cnt;
    accept     = 1'b0;
    reject     = 1'b0;
    case (state)
      IDLE: begin
        if (!mode && (press != 4'b0000)) begin
          if (single_press && others_clear) begin
            accept     = 1'b1;
            lock_next  = LOCK_INIT;
            state_next = LOCKOUT;
          end else begin
            reject     = 1'b1;
            state_next = WAIT_RELEASE;
          end
        end else begin
          state_next = IDLE;
        end
      end
      LOCKOUT: begin
        // Mode is deliberately ignored here so a lockout always completes.
        if (lock_cnt <= LOCK_ONE) begin
          lock_next  = '0;
          state_next = WAIT_RELEASE;
        end else begin
          lock_next  = lock_cnt - LOCK_ONE;
          state_next = LOCKOUT;
        end
      end
      WAIT_RELEASE: begin
        if (level == 4'b0000) begin
          state_next = IDLE;
        end else begin
          state_next = WAIT_RELEASE;
        end
      end
      default: begin
        lock_next  = '0;
        state_next = IDLE;
      end
    endcase
  end

  // FSM state, lockout counter and the registered decision pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      lock_cnt          <= '0;
      valid_vote_casted <= 1'b0;
      invalid_press     <= 1'b0;
    end else begin
      state             <= state_next;
      lock_cnt          <= lock_next;
      valid_vote_casted <= accept;
      invalid_press     <= reject;
    end
  end

  // Saturating tallies; a vote at 255 is still acknowledged but not counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        tally[i] <= 8'd0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (accept && press[i] && (tally[i] != 8'hFF)) begin
          tally[i] <= tally[i] + 8'd1;
        end else begin
          tally[i] <= tally[i];
        end
      end
    end
  end

  assign cand1_vote         = tally[0];
  assign cand2_vote         = tally[1];
  assign cand3_vote         = tally[2];
  assign cand4_vote         = tally[3];
  assign cand1_button_press = level[0];
  assign cand2_button_press = level[1];
  assign cand3_button_press = level[2];
  assign cand4_button_press = level[3];

endmodule

// File: tb/tb_vote_capture.sv
// Scoreboard bench for vote_capture: a behavioural model predicts, per clock,
// the pulse, tallies and debounced levels; a monitor compares on negedge.
module tb_vote_capture;

  localparam int DEB  = 4;
  localparam int LOCK = 10;

  logic       clk;
  logic       reset;
  logic       mode;
  logic [3:0] btn;
  logic [7:0] v1, v2, v3, v4;
  logic       p1, p2, p3, p4;
  logic       vvc, inv;

  int total = 0;
  int bad   = 0;
  int votes_seen = 0;

  typedef struct {
    int kind;   // 0 none, 1 vote, 2 invalid
    int cand;
    int tally;
  } exp_t;
  exp_t q[$];

  // Model state: raw samples seen two edges ago drive the debouncer.
  bit [3:0]   m_s1, m_s2, m_lvl, m_prv;
  int         m_run [4];
  logic [7:0] m_tally [4];
  int         m_busy;   // remaining lockout cycles
  bit         m_wait;   // waiting for all buttons released

  vote_capture #(.DEBOUNCE_CYCLES(DEB), .LOCKOUT_CYCLES(LOCK)) dut (
    .clk(clk), .reset(reset), .mode(mode),
    .button1(btn[0]), .button2(btn[1]), .button3(btn[2]), .button4(btn[3]),
    .cand1_vote(v1), .cand2_vote(v2), .cand3_vote(v3), .cand4_vote(v4),
    .cand1_button_press(p1), .cand2_button_press(p2),
    .cand3_button_press(p3), .cand4_button_press(p4),
    .valid_vote_casted(vvc), .invalid_press(inv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply the rules of one clock edge to the model and queue the expectation.
  task automatic model_edge();
    exp_t     e;
    bit [3:0] pr;
    bit [3:0] nl;
    e.kind = 0; e.cand = 0; e.tally = 0;
    if (reset) begin
      m_s1 = 4'b0; m_s2 = 4'b0; m_lvl = 4'b0; m_prv = 4'b0;
      m_busy = 0; m_wait = 1'b0;
      for (int b = 0; b < 4; b++) begin m_run[b] = 0; m_tally[b] = 8'd0; end
      q.push_back(e);
      return;
    end
    pr = m_lvl & ~m_prv;
    if (m_busy == 0 && !m_wait) begin
      if (!mode && pr != 4'b0) begin
        if ($countones(pr) == 1 && (m_lvl & ~pr) == 4'b0) begin
          for (int b = 0; b < 4; b++) if (pr[b]) e.cand = b;
          if (m_tally[e.cand] < 8'd255) m_tally[e.cand] = m_tally[e.cand] + 8'd1;
          e.kind = 1; e.tally = m_tally[e.cand];
          m_busy = LOCK;
        end else begin
          e.kind = 2;
          m_wait = 1'b1;
        end
      end
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) m_wait = 1'b1;
    end else if (m_lvl == 4'b0) begin
      m_wait = 1'b0;
    end
    nl = m_lvl;
    for (int b = 0; b < 4; b++) begin
      if (m_s2[b] != m_lvl[b]) begin
        m_run[b]++;
        if (m_run[b] == DEB) begin nl[b] = m_s2[b]; m_run[b] = 0; end
      end else begin
        m_run[b] = 0;
      end
    end
    m_prv = m_lvl;
    m_lvl = nl;
    m_s2  = m_s1;
    m_s1  = btn;
    q.push_back(e);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic hold(input int n);
    repeat (n) cycle();
  endtask

  task automatic press_release(input int b, input int hi, input int lo);
    btn[b] = 1'b1; hold(hi);
    btn[b] = 1'b0; hold(lo);
  endtask

  task automatic do_reset();
    reset = 1'b1; btn = 4'b0; mode = 1'b0;
    hold(2);
    reset = 1'b0;
  endtask

  // Monitor: one expectation per clock, compared away from the active edge.
  initial begin
    exp_t e;
    int   dk;
    forever begin
      @(negedge clk);
      if (q.size() == 0) begin
        if (vvc || inv) check("unexpected_pulse", {vvc, inv}, 0);
      end else begin
        e  = q.pop_front();
        dk = (vvc && inv) ? 3 : vvc ? 1 : inv ? 2 : 0;
        if (vvc) votes_seen++;
        check("pulse_kind", dk, e.kind);
        if (e.kind == 1)
          check("vote_tally", (e.cand == 0) ? v1 : (e.cand == 1) ? v2 : (e.cand == 2) ? v3 : v4, e.tally);
        check("tallies", {v4, v3, v2, v1}, {m_tally[3], m_tally[2], m_tally[1], m_tally[0]});
        check("levels", {p4, p3, p2, p1}, m_lvl);
      end
    end
  end

  initial begin
    int base;
    reset = 1'b1; mode = 1'b0; btn = 4'b0;
    hold(3);
    reset = 1'b0;

    // 1: single clean press on button2.
    press_release(1, 20, 20);
    check("t1_cand2", v2, 1);
    check("t1_others", {v4, v3, v1}, 0);

    // 2: glitch shorter than the debounce window.
    press_release(0, 3, 12);
    check("t2_cand1", v1, 0);

    // 3: simultaneous press rejected, then clean press on button3.
    do_reset();
    btn = 4'b1100; hold(10);
    btn = 4'b0000; hold(12);
    press_release(2, 8, 20);
    check("t3_cand3", v3, 1);
    check("t3_cand4", v4, 0);

    // 4: long hold gives one vote; press during lockout ignored.
    do_reset();
    btn[0] = 1'b1; hold(8);
    btn[1] = 1'b1; hold(6);
    btn[1] = 1'b0; hold(26);
    btn[0] = 1'b0; hold(12);
    press_release(1, 8, 20);
    check("t4_cand1", v1, 1);
    check("t4_cand2", v2, 1);

    // 5: saturation after 256 votes on candidate 4.
    do_reset();
    base = votes_seen;
    for (int k = 0; k < 256; k++) press_release(3, 7, 18);
    hold(1);
    check("t5_cand4", v4, 255);
    check("t5_pulses", votes_seen - base, 256);

    // 6: result mode ignores presses; reset mid-lockout clears everything.
    do_reset();
    mode = 1'b1;
    press_release(0, 8, 10);
    check("t6_level_only", v1, 0);
    mode = 1'b0;
    btn[0] = 1'b1; hold(9);
    check("t6_vote", v1, 1);
    reset = 1'b1; hold(1);
    reset = 1'b0;
    check("t6_reset_tallies", {v4, v3, v2, v1}, 0);
    check("t6_reset_pulses", {vvc, inv}, 0);
    btn[0] = 1'b0; hold(12);

    // Randomised phase checked by the model and monitor.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 99) < 3) begin
        reset = 1'b1; hold(1); reset = 1'b0;
      end
      if ($urandom_range(0, 9) == 0) mode = ~mode;
      case ($urandom_range(0, 3))
        0: btn = 4'b0;
        1: btn = 4'(1 << $urandom_range(0, 3));
        default: btn = 4'($urandom_range(0, 15));
      endcase
      hold($urandom_range(1, 20));
    end
    btn = 4'b0; mode = 1'b0;
    hold(20);
    #6;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
